noc_flit_drain: RTL

NOC_FLIT_DRAIN -- requirements
Module: noc_flit_drain

---
 rtl/noc_flit_drain.sv | 133 +++++++++++++
 1 files changed

// File: rtl/noc_flit_drain.sv
// Drains flits from a registered-output FIFO into a valid/ready stream with header/body framing.
// Optional macro FLIT_PARITY_EN adds an m_parity output carried alongside each buffered flit.
module noc_flit_drain #(
    parameter int DWIDTH = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
`ifdef FLIT_PARITY_EN
    output logic              m_parity,
`endif
    output logic [15:0]       pkt_count
);

`ifdef FLIT_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int EW = DWIDTH + PW;

    typedef enum logic {HEAD, BODY} state_t;

    state_t            state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [EW-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [EW-1:0]     in_word;
    logic [LEN_W-1:0]  hdr_len;
    logic [2:0]        pending;
    logic              xfer;

`ifdef FLIT_PARITY_EN
    assign in_word  = {^fifo_dout, fifo_dout};
    assign m_parity = buf0_q[DWIDTH];
`else
    assign in_word  = fifo_dout;
`endif

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf0_q[DWIDTH-1:0];
    assign pkt_count = cnt_q;
    assign hdr_len   = buf0_q[LEN_W-1:0];
    assign xfer      = m_valid && m_ready;

    // Slots still claimed after this cycle's transfer; a new pop may only take the last free one.
    assign pending    = 3'(occ_q) + 3'(inflight_q) - 3'(xfer);
    assign fifo_rd_en = !fifo_empty && !rst && (pending <= 3'd1);

    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        unique case ({xfer, inflight_q})
            2'b01: begin
                if (occ_q == 2'd0) buf0_d = in_word;
                else               buf1_d = in_word;
                occ_d = occ_q + 2'd1;
            end
            2'b10: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = in_word;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = in_word;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        m_first = 1'b0;
        m_last  = 1'b0;
        if (m_valid) begin
            if (state_q == HEAD) begin
                m_first = 1'b1;
                m_last  = (hdr_len == '0);
            end else begin
                m_last  = (rem_q == LEN_W'(1));
            end
        end
        if (xfer) begin
            if (state_q == HEAD) begin
                rem_d = hdr_len;
                if (hdr_len != '0) state_d = BODY;
            end else begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = HEAD;
            end
            if (m_last) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HEAD;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
